freq_meter_gated: RTL and testbench
===================================

Name: freq_meter_gated

Overview:
- Measures the frequency of an external digital signal: counts rising edges over a fixed gate window and reports the count.
- At the default gate of one second on the 100 MHz board clock, the count equals the frequency in Hz.
- Sits beside the frequency divider. The divider generates known rates; this block measures an unknown one.
- Results feed the seven-segment display path, with a pulse for a one-cycle display update.

Parameters:
- GATE_CYCLES, 100000000: gate window length in clk_in cycles (1 s at 100 MHz). Must be at least 2.
- GATE_W, 27: width of the gate counter. Must satisfy 2^GATE_W > GATE_CYCLES-1.
- COUNT_W, 27: width of the edge counter and of freq_out.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous reset, active-low. Clears all state immediately.
- sig_in  input  1  signal under measurement, asynchronous to clk_in.
- continuous  input  1  1 = back-to-back gates with no dead cycle; 0 = single-shot.
- start  input  1  single-cycle request for one gate; sampled only in IDLE.
- freq_out  output  COUNT_W  rising-edge count of the last completed gate; held until the next result.
- valid  output  1  one-cycle pulse when freq_out and overflow update.
- overflow  output  1  1 = the last completed gate saturated the edge counter; held with freq_out.
- busy  output  1  1 while a gate is open (state GATE).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters and sync flops 0, freq_out=0, valid=0, overflow=0, busy=0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
  - rise = s2 & ~s3 (combinational).
  - An edge on sig_in becomes visible as rise after the 2nd clk_in edge and is counted at the 3rd.
- Minimum resolvable sig_in high/low time: more than 1 clk_in period. Faster input is out of spec; no detection is guaranteed.
- State IDLE:
  - busy=0; rise is ignored.
  - If continuous=1 or start=1 at a clock edge: go to GATE with gate_cnt=0, edge_cnt=0, ovf_pend=0.
- State GATE, every cycle:
  - busy=1; gate_cnt increments by 1.
  - If rise=1: edge_cnt increments by 1, saturating at 2^COUNT_W-1.
  - A rise while edge_cnt is already at maximum sets ovf_pend.
- Terminal cycle (gate_cnt == GATE_CYCLES-1):
  - The terminal cycle's rise belongs to this window.
  - At the next clock edge: freq_out <= saturated(edge_cnt + rise); overflow <= ovf_pend | (saturation caused by this rise); valid <= 1 for exactly one cycle.
  - Then, if continuous=1: stay in GATE, gate_cnt=0, edge_cnt=0, ovf_pend=0, with no dead cycle. A rise in the first cycle of the new window is counted there.
  - Otherwise: go to IDLE.
- Window length: each gate spans exactly GATE_CYCLES cycles of rise sampling.
- Single-shot timing: valid asserts GATE_CYCLES cycles after the edge that sampled start.
- start during GATE is ignored; it is not queued.
- continuous is sampled only at IDLE exit and at the terminal cycle. Dropping it mid-gate lets the current gate finish and report, then the block goes to IDLE.
- start and continuous may both be 1 in IDLE: one transition to GATE.
- Reset mid-gate aborts the gate: no valid pulse, freq_out returns to 0.
- Outside valid cycles, freq_out and overflow change only on reset.

Test Plan:
- Basic count (GATE_CYCLES=100, COUNT_W=27, continuous=1): sig_in square wave, period 10 cycles, from reset release → every valid gives freq_out=10, overflow=0; valid pulses exactly 100 cycles apart.
- Single-shot (continuous=0, sig_in period 20): pulse start at cycle t → busy=1 from t+1; valid only at t+100 with freq_out=5; busy=0 afterwards; no further valid over the next 300 cycles.
- Overflow (COUNT_W=4, sig_in period 4, GATE_CYCLES=100) → freq_out=15, overflow=1. Then sig_in period 10 → next valid freq_out=10, overflow=0.
- Boundary edge: sig_in single rising edge timed so rise=1 in the terminal cycle → counted in that window (freq_out=1). An edge one cycle later → counted in the next window; the first window reports 0.
- Ignore cases: start pulsed mid-gate, and edges while IDLE → no extra gate, no count change. continuous dropped at gate_cnt=50 → that gate reports, then IDLE.
- Reset: assert rst at gate_cnt=60 → immediately freq_out=0, valid=0, busy=0. After release with continuous=1 → first valid 100 cycles later with the correct count.

Source files
------------

// File: rtl/freq_meter_gated.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clocks and reports a saturating count.
module freq_meter_gated #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned GATE_W      = 27,
  parameter int unsigned COUNT_W     = 27
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               sig_in,
  input  logic               continuous,
  input  logic               start,
  output logic [COUNT_W-1:0] freq_out,
  output logic               valid,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  state_e               state_q, state_d;
  logic                 s1_q, s2_q, s3_q;
  logic [GATE_W-1:0]    gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [COUNT_W-1:0]   freq_q, freq_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic                 rise;
  logic                 at_max;
  logic                 terminal;

  assign rise     = s2_q & ~s3_q;
  assign at_max   = (edge_cnt_q == COUNT_MAX);
  assign terminal = (gate_cnt_q == GATE_LAST);

  // s1/s2 resolve metastability; s3 delays s2 so a rise lasts one cycle.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop samples its predecessor's old value.
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no path infers a latch.
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_pend_d = ovf_pend_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (continuous || start) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_pend_d = 1'b0;
        end
      end
      GATE: begin
        gate_cnt_d = gate_cnt_q + GATE_W'(1);
        if (rise && !at_max) begin
          edge_cnt_d = edge_cnt_q + COUNT_W'(1);
        end
        ovf_pend_d = ovf_pend_q | (rise & at_max);
        if (terminal) begin
          // The terminal cycle's rise is already folded into edge_cnt_d.
          freq_d     = edge_cnt_d;
          ovf_d      = ovf_pend_d;
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_pend_d = 1'b0;
          if (!continuous) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_pend_q <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_pend_q <= ovf_pend_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_out = freq_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == GATE);

endmodule

// File: tb/tb_freq_meter_gated.sv
// Bench for freq_meter_gated: two instances (wide and 4-bit counters) share
// stimulus and are checked every cycle against a window-sum reference model.
module tb_freq_meter_gated;

  localparam int     G         = 100;
  localparam int     BIG_W     = 27;
  localparam int     SMALL_W   = 4;
  localparam longint BIG_MAX   = (longint'(1) << BIG_W) - 1;
  localparam longint SMALL_MAX = (longint'(1) << SMALL_W) - 1;

  logic clk_in     = 1'b0;
  logic rst        = 1'b0;
  logic sig_in     = 1'b0;
  logic continuous = 1'b0;
  logic start      = 1'b0;

  logic [BIG_W-1:0]   freq_b;
  logic               valid_b, ovf_b, busy_b;
  logic [SMALL_W-1:0] freq_s;
  logic               valid_s, ovf_s, busy_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  freq_meter_gated #(.GATE_CYCLES(G), .GATE_W(7), .COUNT_W(BIG_W)) dut_b (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .continuous(continuous), .start(start),
    .freq_out(freq_b), .valid(valid_b), .overflow(ovf_b), .busy(busy_b)
  );

  freq_meter_gated #(.GATE_CYCLES(G), .GATE_W(7), .COUNT_W(SMALL_W)) dut_s (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .continuous(continuous), .start(start),
    .freq_out(freq_s), .valid(valid_s), .overflow(ovf_s), .busy(busy_s)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sig_in generator: 0 = hold sig_hold, 1 = square wave (high half first), 2 = random levels >= 2 cycles
  int   sig_mode = 0;
  int   sig_per  = 10;
  int   ph       = 0;
  int   rnd_left = 0;
  logic sig_hold = 1'b0;

  always @(negedge clk_in) begin
    case (sig_mode)
      0: sig_in = sig_hold;
      1: begin
        sig_in = ((ph % sig_per) < (sig_per / 2));
        ph++;
      end
      default: begin
        if (rnd_left <= 0) begin
          sig_in   = ~sig_in;
          rnd_left = $urandom_range(2, 7);
        end
        rnd_left--;
      end
    endcase
  end

  // Reference model: history of sig_in samples per clock edge; a gate opened at
  // edge s reports the number of 0->1 transitions seen by edges s+1..s+G, where
  // the transition used at edge m is sample[m-3] -> sample[m-2].
  bit     sig_at [0:32767];
  int     cyc        = 0;
  int     clear_upto = 0;
  int     m_s        = 0;
  bit     m_busy     = 1'b0;
  bit     m_valid    = 1'b0;
  longint m_freq_b   = 0;
  longint m_freq_s   = 0;
  bit     m_ovf_b    = 1'b0;
  bit     m_ovf_s    = 1'b0;

  function automatic bit hist(input int k);
    return (k > clear_upto && k >= 0 && k < 32768) ? sig_at[k] : 1'b0;
  endfunction

  function automatic longint count_rises(input int s);
    longint n = 0;
    for (int m = s + 1; m <= s + G; m++) begin
      if (hist(m - 2) && !hist(m - 3)) n++;
    end
    return n;
  endfunction

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      clear_upto = cyc;
      m_busy     = 1'b0;
      m_valid    = 1'b0;
      m_freq_b   = 0;
      m_freq_s   = 0;
      m_ovf_b    = 1'b0;
      m_ovf_s    = 1'b0;
    end else begin
      longint n;
      cyc++;
      if (cyc < 32768) sig_at[cyc] = sig_in;
      m_valid = 1'b0;
      if (!m_busy) begin
        if (start || continuous) begin
          m_busy = 1'b1;
          m_s    = cyc;
        end
      end else if (cyc == m_s + G) begin
        n        = count_rises(m_s);
        m_freq_b = (n > BIG_MAX) ? BIG_MAX : n;
        m_ovf_b  = (n > BIG_MAX);
        m_freq_s = (n > SMALL_MAX) ? SMALL_MAX : n;
        m_ovf_s  = (n > SMALL_MAX);
        m_valid  = 1'b1;
        if (continuous) m_s = cyc;
        else            m_busy = 1'b0;
      end
    end
  end

  always @(posedge clk_in) begin
    #1;
    check("valid_b", valid_b, m_valid);
    check("freq_b",  freq_b,  m_freq_b);
    check("ovf_b",   ovf_b,   m_ovf_b);
    check("busy_b",  busy_b,  m_busy);
    check("valid_s", valid_s, m_valid);
    check("freq_s",  freq_s,  m_freq_s);
    check("ovf_s",   ovf_s,   m_ovf_s);
    check("busy_s",  busy_s,  m_busy);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    bit done = 1'b0;
    n = 0;
    while (!done) begin
      tick();
      n++;
      if (valid_b) begin
        done = 1'b1;
      end else if (n >= budget) begin
        n_checks++;
        n_errors++;
        $display("FAIL wait_valid: no valid after %0d cycles, required within %0d", n, budget);
        done = 1'b1;
      end
    end
  endtask

  task automatic go_idle();
    int k = 0;
    continuous = 1'b0;
    start      = 1'b0;
    while (busy_b && k < 3 * G) begin
      tick();
      k++;
    end
    check("go_idle_busy", busy_b, 0);
    tick(4);
  endtask

  task automatic single_shot(input int per, output int n);
    sig_mode = 1;
    sig_per  = per;
    ph       = per / 2;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ss_busy_after_start", busy_b, 1);
    wait_valid(G + 5, n);
  endtask

  task automatic count_valids(input int cycles, output int nv);
    nv = 0;
    repeat (cycles) begin
      tick();
      if (valid_b) nv++;
    end
  endtask

  initial begin
    int n;
    int nv;

    // Reset state and basic continuous counting, period 10 from release.
    sig_mode   = 1;
    sig_per    = 10;
    continuous = 1'b1;
    tick(3);
    check("rst_freq",  freq_b,  0);
    check("rst_valid", valid_b, 0);
    check("rst_busy",  busy_b,  0);
    check("rst_ovf",   ovf_b,   0);
    ph  = 5;
    rst = 1'b1;
    // First edge after release opens the gate; valid follows G edges later.
    wait_valid(G + 10, n);
    check("basic_first_latency", n, G + 1);
    check("basic_freq_1", freq_b, 10);
    check("basic_ovf_1",  ovf_b,  0);
    wait_valid(G + 10, n);
    check("basic_spacing", n, G);
    check("basic_freq_2",  freq_b, 10);
    wait_valid(G + 10, n);
    check("basic_freq_3",  freq_b, 10);

    // Single shot, period 20.
    go_idle();
    single_shot(20, n);
    check("ss_latency", n, G);
    check("ss_freq",    freq_b, 5);
    tick(2);
    check("ss_busy_after", busy_b, 0);
    count_valids(300, nv);
    check("ss_no_more_valid", nv, 0);

    // Saturation on the 4-bit instance, then a clean window.
    single_shot(4, n);
    check("ovf_freq_s", freq_s, 15);
    check("ovf_ovf_s",  ovf_s,  1);
    check("ovf_freq_b", freq_b, 25);
    check("ovf_ovf_b",  ovf_b,  0);
    tick(3);
    single_shot(10, n);
    check("ovf_clear_freq_s", freq_s, 10);
    check("ovf_clear_ovf_s",  ovf_s,  0);

    // Single edge whose rise lands in the terminal cycle.
    sig_mode = 0;
    sig_hold = 1'b0;
    tick(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(G - 3);
    sig_hold = 1'b1;
    wait_valid(10, n);
    check("bnd_term_latency", n, 3);
    check("bnd_term_freq", freq_b, 1);

    // Edge one cycle later falls into the next continuous window.
    sig_hold = 1'b0;
    tick(4);
    continuous = 1'b1;
    tick();
    tick(G - 2);
    sig_hold = 1'b1;
    wait_valid(10, n);
    check("bnd_next_latency", n, 2);
    check("bnd_next_freq_w1", freq_b, 0);
    continuous = 1'b0;
    wait_valid(G + 5, n);
    check("bnd_next_freq_w2", freq_b, 1);
    tick(3);
    check("bnd_next_idle", busy_b, 0);

    // start pulsed mid-gate is ignored.
    sig_mode = 1;
    sig_per  = 10;
    ph       = 5;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(40);
    start = 1'b1;
    tick();
    start = 1'b0;
    count_valids(250, nv);
    check("mid_start_valids", nv, 1);
    check("mid_start_idle", busy_b, 0);

    // continuous dropped at gate_cnt = 50.
    continuous = 1'b1;
    tick();
    tick(50);
    continuous = 1'b0;
    wait_valid(G + 5, n);
    check("cont_drop_latency", n, 50);
    tick(3);
    check("cont_drop_idle", busy_b, 0);
    count_valids(150, nv);
    check("cont_drop_no_valid", nv, 0);

    // Reset at gate_cnt = 60 aborts the gate.
    continuous = 1'b1;
    wait_valid(G + 10, n);
    tick(60);
    check("pre_rst_busy", busy_b, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_freq_b",  freq_b,  0);
    check("mid_rst_valid_b", valid_b, 0);
    check("mid_rst_busy_b",  busy_b,  0);
    check("mid_rst_ovf_b",   ovf_b,   0);
    check("mid_rst_freq_s",  freq_s,  0);
    check("mid_rst_busy_s",  busy_s,  0);
    tick(3);
    ph  = 5;
    rst = 1'b1;
    wait_valid(G + 10, n);
    check("post_rst_latency", n, G + 1);
    check("post_rst_freq", freq_b, 10);

    // Randomized traffic against the model.
    sig_mode = 2;
    repeat (3000) begin
      tick();
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) continuous = ~continuous;
    end
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
